// File: rtl/writeback_unit.sv
// Retire stage: buffers execute/memory results in a small FIFO and writes back one per cycle.
// Retires to r15 turn into PC redirects. A per-register pending counter lets decode stall reads.
module writeback_unit #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     issue_valid_i,
  input  logic [3:0]               issue_addr_i,
  input  logic                     res_valid_i,
  output logic                     res_ready_o,
  input  logic [3:0]               res_addr_i,
  input  logic [DATA_W-1:0]        res_data_i,
  input  logic                     stall_i,
  output logic                     wr_en_o,
  output logic [3:0]               wr_addr_o,
  output logic [DATA_W-1:0]        data_o,
  output logic                     branch_o,
  output logic [DATA_W-1:0]        branch_target_o,
  input  logic [3:0]               r1_addr_i,
  input  logic [3:0]               r2_addr_i,
  output logic                     r1_busy_o,
  output logic                     r2_busy_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0] PC_REG = 4'd15;

  logic [3:0]        addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  pending [16];

  logic              push, pop;
  logic [3:0]        head_addr;
  logic [DATA_W-1:0] head_data;

  // Saturating pending counter step; simultaneous inc and dec cancel.
  function automatic logic [CNT_W-1:0] pend_next(input logic [CNT_W-1:0] cur,
                                                 input logic inc, input logic dec);
    if (inc && !dec && cur != CNT_MAX) return cur + CNT_W'(1);
    if (dec && !inc && cur != '0)      return cur - CNT_W'(1);
    return cur;
  endfunction

  assign res_ready_o = !reset_i && (count_o != (AW+1)'(DEPTH));
  assign push        = res_valid_i && res_ready_o;
  assign pop         = (count_o != '0) && !stall_i;
  assign head_addr   = addr_mem[rd_ptr];
  assign head_data   = data_mem[rd_ptr];

  assign r1_busy_o = (r1_addr_i != PC_REG) && (pending[r1_addr_i] != '0);
  assign r2_busy_o = (r2_addr_i != PC_REG) && (pending[r2_addr_i] != '0);

  // Stage: FIFO storage (data only, no reset needed)
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr] <= res_addr_i;
      data_mem[wr_ptr] <= res_data_i;
    end
  end

  // Stage: pointers, occupancy, scoreboard and registered retire outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count_o         <= '0;
      wr_en_o         <= 1'b0;
      wr_addr_o       <= '0;
      data_o          <= '0;
      branch_o        <= 1'b0;
      branch_target_o <= '0;
      for (int r = 0; r < 16; r++) pending[r] <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count_o <= count_o + 1'b1;
      else if (pop && !push) count_o <= count_o - 1'b1;

      wr_en_o  <= 1'b0;
      branch_o <= 1'b0;
      if (pop) begin
        if (head_addr == PC_REG) begin
          branch_o        <= 1'b1;
          branch_target_o <= {head_data[DATA_W-1:2], 2'b00};
        end else begin
          wr_en_o   <= 1'b1;
          wr_addr_o <= head_addr;
          data_o    <= head_data;
        end
      end

      // r15 is never tracked, so its counter stays at zero.
      for (int r = 0; r < 16; r++) begin
        pending[r] <= pend_next(pending[r],
                                (r != 15) && issue_valid_i && (issue_addr_i == 4'(r)),
                                (r != 15) && pop && (head_addr == 4'(r)));
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: vector table for single-cycle behaviour plus
// hand-written sequences for stall/backpressure, reset flush and counter saturation.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        issue_valid_i;
  logic [3:0]  issue_addr_i;
  logic        res_valid_i;
  logic        res_ready_o;
  logic [3:0]  res_addr_i;
  logic [31:0] res_data_i;
  logic        stall_i;
  logic        wr_en_o;
  logic [3:0]  wr_addr_o;
  logic [31:0] data_o;
  logic        branch_o;
  logic [31:0] branch_target_o;
  logic [3:0]  r1_addr_i, r2_addr_i;
  logic        r1_busy_o, r2_busy_o;
  logic [2:0]  count_o;

  int checks = 0;
  int errors = 0;

  writeback_unit #(.DEPTH(4), .DATA_W(32), .CNT_W(3)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .issue_valid_i(issue_valid_i), .issue_addr_i(issue_addr_i),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
    .res_addr_i(res_addr_i), .res_data_i(res_data_i),
    .stall_i(stall_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .data_o(data_o),
    .branch_o(branch_o), .branch_target_o(branch_target_o),
    .r1_addr_i(r1_addr_i), .r2_addr_i(r2_addr_i),
    .r1_busy_o(r1_busy_o), .r2_busy_o(r2_busy_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        iv;
    logic [3:0]  ia;
    logic        rv;
    logic [3:0]  ra;
    logic [31:0] rd;
    logic        st;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic        e_wr;
    logic [3:0]  e_wa;
    logic [31:0] e_d;
    logic        e_br;
    logic [31:0] e_bt;
    logic        e_b1;
    logic        e_b2;
    logic [2:0]  e_cnt;
    logic        e_rdy;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid_i = 1'b0; issue_addr_i = 4'd0;
    res_valid_i = 1'b0; res_addr_i = 4'd0; res_data_i = 32'd0;
    stall_i = 1'b0;
  endtask

  initial begin
    // iv ia rv ra rd st a1 a2 | wr wa d br bt b1 b2 cnt rdy
    vecs[0]  = '{1'b0,4'd0, 1'b1,4'd3, 32'hDEADBEEF,1'b0,4'd3,4'd15, 1'b0,4'd0,32'h0,       1'b0,32'h0,    1'b0,1'b0,3'd1,1'b1};
    vecs[1]  = '{1'b0,4'd0, 1'b0,4'd0, 32'h0,       1'b0,4'd3,4'd15, 1'b1,4'd3,32'hDEADBEEF,1'b0,32'h0,    1'b0,1'b0,3'd0,1'b1};
    vecs[2]  = '{1'b0,4'd0, 1'b0,4'd0, 32'h0,       1'b0,4'd3,4'd15, 1'b0,4'd3,32'hDEADBEEF,1'b0,32'h0,    1'b0,1'b0,3'd0,1'b1};
    vecs[3]  = '{1'b1,4'd5, 1'b0,4'd0, 32'h0,       1'b0,4'd5,4'd15, 1'b0,4'd3,32'hDEADBEEF,1'b0,32'h0,    1'b1,1'b0,3'd0,1'b1};
    vecs[4]  = '{1'b1,4'd5, 1'b1,4'd5, 32'h11,      1'b0,4'd5,4'd5,  1'b0,4'd3,32'hDEADBEEF,1'b0,32'h0,    1'b1,1'b1,3'd1,1'b1};
    vecs[5]  = '{1'b0,4'd0, 1'b1,4'd5, 32'h22,      1'b0,4'd5,4'd15, 1'b1,4'd5,32'h11,      1'b0,32'h0,    1'b1,1'b0,3'd1,1'b1};
    vecs[6]  = '{1'b0,4'd0, 1'b0,4'd0, 32'h0,       1'b0,4'd5,4'd15, 1'b1,4'd5,32'h22,      1'b0,32'h0,    1'b0,1'b0,3'd0,1'b1};
    vecs[7]  = '{1'b0,4'd0, 1'b0,4'd0, 32'h0,       1'b0,4'd5,4'd15, 1'b0,4'd5,32'h22,      1'b0,32'h0,    1'b0,1'b0,3'd0,1'b1};
    vecs[8]  = '{1'b1,4'd15,1'b1,4'd15,32'h00001007,1'b0,4'd5,4'd15, 1'b0,4'd5,32'h22,      1'b0,32'h0,    1'b0,1'b0,3'd1,1'b1};
    vecs[9]  = '{1'b0,4'd0, 1'b0,4'd0, 32'h0,       1'b0,4'd5,4'd15, 1'b0,4'd5,32'h22,      1'b1,32'h1004, 1'b0,1'b0,3'd0,1'b1};
    vecs[10] = '{1'b0,4'd0, 1'b0,4'd0, 32'h0,       1'b0,4'd5,4'd15, 1'b0,4'd5,32'h22,      1'b0,32'h1004, 1'b0,1'b0,3'd0,1'b1};
    vecs[11] = '{1'b1,4'd2, 1'b0,4'd0, 32'h0,       1'b0,4'd2,4'd15, 1'b0,4'd5,32'h22,      1'b0,32'h1004, 1'b1,1'b0,3'd0,1'b1};
    vecs[12] = '{1'b0,4'd0, 1'b1,4'd2, 32'h33,      1'b0,4'd2,4'd15, 1'b0,4'd5,32'h22,      1'b0,32'h1004, 1'b1,1'b0,3'd1,1'b1};
    vecs[13] = '{1'b1,4'd2, 1'b0,4'd0, 32'h0,       1'b0,4'd2,4'd2,  1'b1,4'd2,32'h33,      1'b0,32'h1004, 1'b1,1'b1,3'd0,1'b1};
    vecs[14] = '{1'b0,4'd0, 1'b1,4'd2, 32'h44,      1'b0,4'd2,4'd15, 1'b0,4'd2,32'h33,      1'b0,32'h1004, 1'b1,1'b0,3'd1,1'b1};
    vecs[15] = '{1'b0,4'd0, 1'b0,4'd0, 32'h0,       1'b0,4'd2,4'd15, 1'b1,4'd2,32'h44,      1'b0,32'h1004, 1'b0,1'b0,3'd0,1'b1};

    idle_inputs();
    r1_addr_i = 4'd0; r2_addr_i = 4'd15;
    reset_i = 1'b1;
    step();
    step();
    chk("rst_ready", {31'd0, res_ready_o}, 32'd0);
    chk("rst_count", {29'd0, count_o}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en_o}, 32'd0);
    chk("rst_wr_addr", {28'd0, wr_addr_o}, 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_branch", {31'd0, branch_o}, 32'd0);
    chk("rst_target", branch_target_o, 32'd0);
    reset_i = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, res_ready_o}, 32'd1);

    // Table: single-result latency, scoreboard, branch, same-edge inc/dec.
    for (int i = 0; i < 16; i++) begin
      issue_valid_i = vecs[i].iv; issue_addr_i = vecs[i].ia;
      res_valid_i = vecs[i].rv;   res_addr_i = vecs[i].ra; res_data_i = vecs[i].rd;
      stall_i = vecs[i].st;       r1_addr_i = vecs[i].a1;  r2_addr_i = vecs[i].a2;
      step();
      chk($sformatf("v%0d_wr_en", i),   {31'd0, wr_en_o},   {31'd0, vecs[i].e_wr});
      chk($sformatf("v%0d_wr_addr", i), {28'd0, wr_addr_o}, {28'd0, vecs[i].e_wa});
      chk($sformatf("v%0d_data", i),    data_o,             vecs[i].e_d);
      chk($sformatf("v%0d_branch", i),  {31'd0, branch_o},  {31'd0, vecs[i].e_br});
      chk($sformatf("v%0d_target", i),  branch_target_o,    vecs[i].e_bt);
      chk($sformatf("v%0d_r1_busy", i), {31'd0, r1_busy_o}, {31'd0, vecs[i].e_b1});
      chk($sformatf("v%0d_r2_busy", i), {31'd0, r2_busy_o}, {31'd0, vecs[i].e_b2});
      chk($sformatf("v%0d_count", i),   {29'd0, count_o},   {29'd0, vecs[i].e_cnt});
      chk($sformatf("v%0d_ready", i),   {31'd0, res_ready_o}, {31'd0, vecs[i].e_rdy});
    end

    // Stall fills the FIFO, fifth result is held by the producer.
    idle_inputs();
    r1_addr_i = 4'd0; r2_addr_i = 4'd15;
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      res_valid_i = 1'b1; res_addr_i = 4'(i + 1); res_data_i = 32'hA0 + 32'(i);
      step();
      chk($sformatf("stall_count%0d", i), {29'd0, count_o}, 32'(i + 1));
      chk($sformatf("stall_no_wr%0d", i), {31'd0, wr_en_o}, 32'd0);
    end
    res_addr_i = 4'd5; res_data_i = 32'hA4;
    chk("full_ready", {31'd0, res_ready_o}, 32'd0);
    step();
    chk("full_hold_count", {29'd0, count_o}, 32'd4);
    chk("full_hold_ready", {31'd0, res_ready_o}, 32'd0);
    stall_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) chk("ready_reassert", {31'd0, res_ready_o}, 32'd1);
      if (i == 1) res_valid_i = 1'b0;
      chk($sformatf("drain_wr_en%0d", i), {31'd0, wr_en_o}, 32'd1);
      chk($sformatf("drain_addr%0d", i), {28'd0, wr_addr_o}, 32'(i + 1));
      chk($sformatf("drain_data%0d", i), data_o, 32'hA0 + 32'(i));
    end
    step();
    chk("drain_done_count", {29'd0, count_o}, 32'd0);
    chk("drain_done_wr", {31'd0, wr_en_o}, 32'd0);

    // Reset with buffered entries and pending writes discards everything.
    idle_inputs();
    stall_i = 1'b1;
    r1_addr_i = 4'd2;
    issue_valid_i = 1'b1; issue_addr_i = 4'd2;
    step();
    step();
    issue_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      res_valid_i = 1'b1; res_addr_i = (i == 2) ? 4'd15 : 4'd2; res_data_i = 32'hB0 + 32'(i);
      step();
    end
    res_valid_i = 1'b0;
    chk("pre_rst_count", {29'd0, count_o}, 32'd3);
    chk("pre_rst_busy", {31'd0, r1_busy_o}, 32'd1);
    reset_i = 1'b1;
    step();
    chk("mid_rst_count", {29'd0, count_o}, 32'd0);
    chk("mid_rst_busy", {31'd0, r1_busy_o}, 32'd0);
    chk("mid_rst_ready", {31'd0, res_ready_o}, 32'd0);
    reset_i = 1'b0;
    stall_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("post_rst_wr%0d", i), {31'd0, wr_en_o}, 32'd0);
      chk($sformatf("post_rst_br%0d", i), {31'd0, branch_o}, 32'd0);
      chk($sformatf("post_rst_cnt%0d", i), {29'd0, count_o}, 32'd0);
    end

    // Pending counter saturates at 7: eight issues, then seven retires clear it.
    idle_inputs();
    r1_addr_i = 4'd7;
    issue_valid_i = 1'b1; issue_addr_i = 4'd7;
    for (int i = 0; i < 8; i++) step();
    issue_valid_i = 1'b0;
    chk("sat_busy", {31'd0, r1_busy_o}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      res_valid_i = 1'b1; res_addr_i = 4'd7; res_data_i = 32'hC0 + 32'(i);
      step();
    end
    res_valid_i = 1'b0;
    chk("sat_busy_one_left", {31'd0, r1_busy_o}, 32'd1);
    step();
    chk("sat_busy_cleared", {31'd0, r1_busy_o}, 32'd0);
    chk("sat_last_data", data_o, 32'hC6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
